fetch_sequencer: RTL and testbench

Sequences instruction fetch from the byte-wide program memory into the 16-bit decoder interface. It reads an opcode byte and, when required, an operand byte, then packs them as {opcode, operand}. The packed word goes to the decoder over a start/ready handshake, after which the program counter advances. The block sits between the program memory read port and the instruction decoder, and also handles jump redirects and halt.

---
 rtl/fetch_sequencer_if.sv | 27 ++
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, byte-wide program memory and the instruction decoder.
// The master side is the sequencer; the slave side is the memory/decoder environment.
interface fetch_sequencer_if #(
  parameter int BYTE   = 8,
  parameter int ADDR_W = 8
);
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BYTE-1:0]     mem_rdata;
  logic                dec_start;
  logic [2*BYTE-1:0]   dec_data;
  logic                dec_ready;
  logic                jump_valid;
  logic [ADDR_W-1:0]   jump_addr;
  logic [ADDR_W-1:0]   pc;
  logic                halted;

  modport master (
    output mem_rd_en, mem_addr, dec_start, dec_data, pc, halted,
    input  mem_rdata, dec_ready, jump_valid, jump_addr
  );

  modport slave (
    input  mem_rd_en, mem_addr, dec_start, dec_data, pc, halted,
    output mem_rdata, dec_ready, jump_valid, jump_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches one- or two-byte instructions from byte-wide program memory and hands
// {opcode, operand} to the decoder over a start/ready handshake; supports jumps and halt.
module fetch_sequencer #(
  parameter int              BYTE        = 8,
  parameter int              ADDR_W      = 8,
  parameter logic [BYTE-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH_OP,
    WAIT_OP,
    FETCH_ARG,
    WAIT_ARG,
    SEND,
    HALT
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt;
  logic                rd_en_q, rd_en_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                start_q, start_nxt;
  logic [2*BYTE-1:0]   data_q, data_nxt;
  logic [BYTE-1:0]     opcode_q, opcode_nxt;
  logic [BYTE-1:0]     operand_q, operand_nxt;
  logic                halted_q, halted_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH_OP;
      pc_q      <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      rd_en_q   <= rd_en_nxt;
      addr_q    <= addr_nxt;
      start_q   <= start_nxt;
      data_q    <= data_nxt;
      opcode_q  <= opcode_nxt;
      operand_q <= operand_nxt;
      halted_q  <= halted_nxt;
    end
  end

  // The read strobe is registered on entry to a fetch state, so FETCH_OP/FETCH_ARG
  // cycles carry the strobe. FETCH_OP without the strobe (after reset, or after a
  // jump out of a strobe cycle) spends one cycle issuing it first.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    rd_en_nxt   = 1'b0;
    addr_nxt    = addr_q;
    start_nxt   = start_q;
    data_nxt    = data_q;
    opcode_nxt  = opcode_q;
    operand_nxt = operand_q;
    halted_nxt  = halted_q;

    case (state)
      FETCH_OP: begin
        if (rd_en_q) begin
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = WAIT_OP;
        end else begin
          rd_en_nxt = 1'b1;
          addr_nxt  = pc_q;
        end
      end
      WAIT_OP: begin
        opcode_nxt = bus.mem_rdata;
        if (bus.mem_rdata == HALT_OPCODE) begin
          state_nxt  = HALT;
          halted_nxt = 1'b1;
        end else if (bus.mem_rdata[BYTE-1]) begin
          state_nxt = FETCH_ARG;
          rd_en_nxt = 1'b1;
          addr_nxt  = pc_q;
        end else begin
          operand_nxt = '0;
          state_nxt   = SEND;
        end
      end
      FETCH_ARG: begin
        pc_nxt    = pc_q + ADDR_W'(1);
        state_nxt = WAIT_ARG;
      end
      WAIT_ARG: begin
        operand_nxt = bus.mem_rdata;
        state_nxt   = SEND;
      end
      SEND: begin
        if (!start_q) begin
          start_nxt = 1'b1;
          data_nxt  = {opcode_q, operand_q};
        end else if (bus.dec_ready) begin
          start_nxt = 1'b0;
          state_nxt = FETCH_OP;
          rd_en_nxt = 1'b1;
          addr_nxt  = pc_q;
        end
      end
      HALT: begin
      end
      default: state_nxt = FETCH_OP;
    endcase

    // A jump discards whatever the current state was collecting; a transfer already
    // accepted this cycle has completed at the decoder and is unaffected.
    if (bus.jump_valid && state != HALT) begin
      state_nxt   = FETCH_OP;
      pc_nxt      = bus.jump_addr;
      rd_en_nxt   = !rd_en_q;
      addr_nxt    = bus.jump_addr;
      start_nxt   = 1'b0;
      data_nxt    = data_q;
      opcode_nxt  = opcode_q;
      operand_nxt = operand_q;
      halted_nxt  = halted_q;
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.dec_start = start_q;
  assign bus.dec_data  = data_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level instruction-stream model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.BYTE(8), .ADDR_W(8)) bus ();

  fetch_sequencer #(.BYTE(8), .ADDR_W(8), .HALT_OPCODE(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];

  // Synchronous memory: data appears the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    else               bus.mem_rdata <= 8'($urandom);
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  op;
    logic [7:0]  arg;
    logic [15:0] exp_data;
    logic [7:0]  exp_pc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  p;
  } xfer_t;

  vec_t  vecs [6];
  xfer_t expq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    bus.jump_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_xfer(input int budget, output logic [15:0] d, output logic [7:0] p,
                           output bit ok);
    ok = 1'b0;
    d  = '0;
    p  = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.dec_start && bus.dec_ready) begin
        d  = bus.dec_data;
        p  = bus.pc;
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !bus.dec_start; i++) tick();
    ok = bus.dec_start;
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  p;
    logic [7:0]  a1;
    logic [15:0] d0;
    bit          ok;
    int          lat;
    int          got;
    int          viol;

    bus.dec_ready  = 1'b0;
    bus.jump_valid = 1'b0;
    bus.jump_addr  = 8'h00;

    vecs[0] = '{8'h00, 8'h12, 8'h34, 16'h1200, 8'h01, 3};
    vecs[1] = '{8'h00, 8'h85, 8'hAB, 16'h85AB, 8'h02, 5};
    vecs[2] = '{8'hFF, 8'h90, 8'h55, 16'h9055, 8'h01, 5};
    vecs[3] = '{8'h40, 8'h7F, 8'h11, 16'h7F00, 8'h41, 3};
    vecs[4] = '{8'h10, 8'h80, 8'h00, 16'h8000, 8'h12, 5};
    vecs[5] = '{8'hFE, 8'h01, 8'hC3, 16'h0100, 8'hFF, 3};

    // Reset state
    clear_mem();
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    bus.dec_ready = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          32'({bus.pc, bus.halted, bus.dec_start, bus.mem_rd_en, bus.mem_addr, bus.dec_data}),
          32'(0));

    // Two sequential one-byte instructions from reset
    reset = 1'b1;
    wait_xfer(20, d, p, ok);
    check("seq1_first_seen", 32'(ok), 32'(1));
    check("seq1_first_data", 32'(d), 32'h1200);
    check("seq1_first_pc", 32'(p), 32'h01);
    wait_xfer(20, d, p, ok);
    check("seq1_second_data", 32'(d), 32'h3400);
    check("seq1_second_pc", 32'(p), 32'h02);

    // Vector table: one instruction placed at a jump target
    for (int v = 0; v < 6; v++) begin
      clear_mem();
      a1 = vecs[v].addr + 8'd1;
      mem[vecs[v].addr] = vecs[v].op;
      mem[a1] = vecs[v].arg;
      bus.dec_ready = 1'b1;
      pulse_reset();
      bus.jump_valid = 1'b1;
      bus.jump_addr  = vecs[v].addr;
      tick();
      bus.jump_valid = 1'b0;
      check("vec_first_read", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, vecs[v].addr}));
      lat = 0;
      while (!bus.dec_start && lat < 20) begin
        tick();
        lat++;
      end
      check("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
      wait_xfer(5, d, p, ok);
      check("vec_seen", 32'(ok), 32'(1));
      check("vec_data", 32'(d), 32'(vecs[v].exp_data));
      check("vec_pc", 32'(p), 32'(vecs[v].exp_pc));
    end

    // Decoder stall holds the instruction without further reads
    clear_mem();
    mem[0] = 8'h12;
    bus.dec_ready = 1'b0;
    pulse_reset();
    wait_start(20, ok);
    check("stall_start_seen", 32'(ok), 32'(1));
    d0 = bus.dec_data;
    check("stall_data", 32'(d0), 32'h1200);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 32'({bus.dec_start, bus.dec_data, bus.mem_rd_en}),
            32'({1'b1, 16'h1200, 1'b0}));
    end
    bus.dec_ready = 1'b1;
    tick();
    check("stall_drop", 32'({bus.dec_start, bus.mem_rd_en, bus.mem_addr}),
          32'({1'b0, 1'b1, 8'h01}));

    // Jump during operand wait discards the partial instruction
    clear_mem();
    mem[0]    = 8'h85;
    mem[1]    = 8'hAB;
    mem[8'h40] = 8'h12;
    bus.dec_ready = 1'b1;
    pulse_reset();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.mem_rd_en && bus.mem_addr == 8'h01) ok = 1'b1;
      else tick();
    end
    check("jarg_arg_read", 32'(ok), 32'(1));
    tick();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'h40;
    tick();
    bus.jump_valid = 1'b0;
    check("jarg_redirect", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, 8'h40}));
    wait_xfer(20, d, p, ok);
    check("jarg_next_data", 32'(d), 32'h1200);
    check("jarg_next_pc", 32'(p), 32'h41);

    // Jump coincident with a transfer: transfer happens once, then redirect
    clear_mem();
    mem[0]     = 8'h12;
    mem[8'h40] = 8'h7A;
    bus.dec_ready = 1'b0;
    pulse_reset();
    wait_start(20, ok);
    check("jx_data", 32'(bus.dec_data), 32'h1200);
    bus.dec_ready  = 1'b1;
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'h40;
    tick();
    bus.jump_valid = 1'b0;
    check("jx_after", 32'({bus.dec_start, bus.mem_rd_en, bus.mem_addr}),
          32'({1'b0, 1'b1, 8'h40}));
    wait_xfer(20, d, p, ok);
    check("jx_next_data", 32'(d), 32'h7A00);
    check("jx_next_pc", 32'(p), 32'h41);

    // Jump in SEND without ready drops the pending instruction
    bus.dec_ready = 1'b0;
    wait_start(20, ok);
    check("jdrop_data", 32'(bus.dec_data), 32'h0000);
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 8'h40;
    tick();
    bus.jump_valid = 1'b0;
    check("jdrop_start", 32'(bus.dec_start), 32'(0));
    bus.dec_ready = 1'b1;
    wait_xfer(20, d, p, ok);
    check("jdrop_next_data", 32'(d), 32'h7A00);

    // Halt stops fetching, ignores jumps; reset restarts
    clear_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'h03;
    mem[3] = 8'hFF;
    bus.dec_ready = 1'b1;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      wait_xfer(20, d, p, ok);
      check("halt_pre_data", 32'(d), 32'({8'(k + 1), 8'h00}));
    end
    for (int i = 0; i < 20 && !bus.halted; i++) begin
      check("halt_no_start", 32'(bus.dec_start), 32'(0));
      tick();
    end
    check("halt_reached", 32'(bus.halted), 32'(1));
    for (int i = 0; i < 8; i++) begin
      bus.jump_valid = (i == 2);
      bus.jump_addr  = 8'h40;
      tick();
      check("halt_hold", 32'({bus.halted, bus.dec_start, bus.mem_rd_en, bus.pc}),
            32'({1'b1, 1'b0, 1'b0, 8'h04}));
    end
    bus.jump_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("halt_reset", 32'({bus.pc, bus.halted, bus.dec_start, bus.mem_rd_en}), 32'(0));
    wait_xfer(20, d, p, ok);
    check("halt_restart_data", 32'(d), 32'h0100);

    // Randomized program with random decoder back-pressure
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'hFF) mem[i] = 8'hFE;
    end
    expq.delete();
    p = 8'h00;
    for (int k = 0; k < 100; k++) begin
      xfer_t x;
      logic [7:0] op;
      logic [7:0] arg;
      op = mem[p];
      p  = p + 8'd1;
      arg = 8'h00;
      if (op >= 8'h80) begin
        arg = mem[p];
        p   = p + 8'd1;
      end
      x.d = {op, arg};
      x.p = p;
      expq.push_back(x);
    end
    bus.dec_ready = 1'b0;
    pulse_reset();
    got  = 0;
    viol = 0;
    for (int c = 0; c < 6000 && got < 100; c++) begin
      logic prev_rd;
      logic prev_stall;
      logic [15:0] prev_d;
      bus.dec_ready = ($urandom_range(0, 9) < 6);
      if (bus.dec_start && bus.dec_ready) begin
        check("rand_data", 32'(bus.dec_data), 32'(expq[got].d));
        check("rand_pc", 32'(bus.pc), 32'(expq[got].p));
        got++;
      end
      prev_rd    = bus.mem_rd_en;
      prev_stall = bus.dec_start && !bus.dec_ready;
      prev_d     = bus.dec_data;
      tick();
      if (prev_rd && bus.mem_rd_en) viol++;
      if (prev_stall && !(bus.dec_start && bus.dec_data == prev_d)) viol++;
    end
    check("rand_count", 32'(got), 32'(100));
    check("rand_protocol", 32'(viol), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
